// File: rtl/vga_cfg_axil_regs_pkg.sv
// Shared types and register map for the VGA configuration AXI4-Lite block.
package vga_cfg_axil_regs_pkg;

  typedef enum logic [1:0] {
    VGA_RES_800_600   = 2'd0,
    VGA_RES_1280_1024 = 2'd1,
    VGA_RES_1024_768  = 2'd2
  } vga_resolution_e;

  localparam logic [1:0] VGA_RES_NUM = 2'd3;

  localparam logic [10:0] VGA_CFG_CTRL_ADDR    = 11'h000;
  localparam logic [10:0] VGA_CFG_STATUS_ADDR  = 11'h004;
  localparam logic [10:0] VGA_CFG_SCRATCH_ADDR = 11'h008;
  localparam logic [10:0] VGA_CFG_ID_ADDR      = 11'h00C;

  localparam int unsigned CTRL_REQ_BIT    = 0;
  localparam int unsigned CTRL_RES_LSB    = 8;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_CTRL    = 3'd0,
    SEL_STATUS  = 3'd1,
    SEL_SCRATCH = 3'd2,
    SEL_ID      = 3'd3,
    SEL_NONE    = 3'd4
  } reg_sel_e;

  // Word index is addr[10:2]; the byte offset within a word is ignored.
  function automatic reg_sel_e decode_word(input logic [8:0] word);
    reg_sel_e sel;
    case (word)
      VGA_CFG_CTRL_ADDR[10:2]:    sel = SEL_CTRL;
      VGA_CFG_STATUS_ADDR[10:2]:  sel = SEL_STATUS;
      VGA_CFG_SCRATCH_ADDR[10:2]: sel = SEL_SCRATCH;
      VGA_CFG_ID_ADDR[10:2]:      sel = SEL_ID;
      default:                    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/vga_cfg_axil_regs.sv
// AXI4-Lite responder for VGA configuration/status; issues one-cycle
// reconfiguration requests to vga_clk_gen and tracks its completion.
module vga_cfg_axil_regs
  import vga_cfg_axil_regs_pkg::*;
#(
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE    = 32'h5647_4131
) (
  input  logic            clk_100m_i,
  input  logic            rstn_i,
  input  logic [10:0]     s_axi_awaddr,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [31:0]     s_axi_wdata,
  input  logic [3:0]      s_axi_wstrb,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [10:0]     s_axi_araddr,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  output vga_resolution_e resolution_o,
  output logic            req_o,
  input  logic            valid_i
);

  logic            aw_held_r;
  logic [8:0]      aw_word_r;
  logic            w_held_r;
  logic [31:0]     w_data_r;
  logic [3:0]      w_strb_r;
  logic            bvalid_r;
  logic [1:0]      bresp_r;
  logic            rvalid_r;
  logic [31:0]     rdata_r;
  logic [1:0]      rresp_r;
  vga_resolution_e res_r;
  logic [31:0]     scratch_r;
  logic            busy_r;
  logic            done_r;
  logic            req_r;

  logic            aw_hs_s;
  logic            w_hs_s;
  logic            ar_hs_s;
  logic            do_write_s;
  logic [1:0]      wr_resp_s;
  logic [1:0]      ctrl_res_s;
  vga_resolution_e res_nxt_s;
  logic [31:0]     scratch_nxt_s;
  logic            req_fire_s;
  logic [31:0]     rd_data_s;
  logic [1:0]      rd_resp_s;
  logic            unused_s;

  assign unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = ~aw_held_r & ~bvalid_r;
  assign s_axi_wready  = ~w_held_r & ~bvalid_r;
  assign s_axi_arready = ~rvalid_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign resolution_o  = res_r;
  assign req_o         = req_r;

  assign aw_hs_s    = s_axi_awvalid & s_axi_awready;
  assign w_hs_s     = s_axi_wvalid & s_axi_wready;
  assign ar_hs_s    = s_axi_arvalid & s_axi_arready;
  assign do_write_s = aw_held_r & w_held_r;

  // Write decode: a rejected CTRL write leaves every field untouched.
  always_comb begin
    wr_resp_s     = AXI_RESP_SLVERR;
    res_nxt_s     = res_r;
    scratch_nxt_s = scratch_r;
    req_fire_s    = 1'b0;
    ctrl_res_s    = res_r;
    case (decode_word(aw_word_r))
      SEL_CTRL: begin
        if (w_strb_r[1]) begin
          ctrl_res_s = w_data_r[CTRL_RES_LSB +: 2];
        end else begin
          ctrl_res_s = res_r;
        end
        if (busy_r || (ctrl_res_s >= VGA_RES_NUM)) begin
          wr_resp_s = AXI_RESP_SLVERR;
        end else begin
          wr_resp_s  = AXI_RESP_OKAY;
          res_nxt_s  = vga_resolution_e'(ctrl_res_s);
          req_fire_s = w_strb_r[0] & w_data_r[CTRL_REQ_BIT];
        end
      end
      SEL_SCRATCH: begin
        wr_resp_s     = AXI_RESP_OKAY;
        scratch_nxt_s = apply_wstrb(scratch_r, w_data_r, w_strb_r);
      end
      default: begin
        wr_resp_s = AXI_RESP_SLVERR;
      end
    endcase
  end

  // Read decode from current register values (pre-update on a shared edge).
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = AXI_RESP_OKAY;
    case (decode_word(s_axi_araddr[10:2]))
      SEL_CTRL:    rd_data_s[CTRL_RES_LSB +: 2] = res_r;
      SEL_STATUS: begin
        rd_data_s[STATUS_BUSY_BIT] = busy_r;
        rd_data_s[STATUS_DONE_BIT] = done_r;
      end
      SEL_SCRATCH: rd_data_s = scratch_r;
      SEL_ID:      rd_data_s = ID_VALUE;
      default:     rd_resp_s = AXI_RESP_SLVERR;
    endcase
  end

  // Write channel: independent AW/W holding registers and response.
  always_ff @(posedge clk_100m_i) begin
    if (!rstn_i) begin
      aw_held_r <= 1'b0;
      aw_word_r <= 9'd0;
      w_held_r  <= 1'b0;
      w_data_r  <= 32'h0000_0000;
      w_strb_r  <= 4'h0;
      bvalid_r  <= 1'b0;
      bresp_r   <= AXI_RESP_OKAY;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        aw_word_r <= s_axi_awaddr[10:2];
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        w_data_r <= s_axi_wdata;
        w_strb_r <= s_axi_wstrb;
      end
      if (do_write_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= wr_resp_s;
      end else if (bvalid_r && s_axi_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read channel: single outstanding read, response held until rready.
  always_ff @(posedge clk_100m_i) begin
    if (!rstn_i) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rresp_r  <= AXI_RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  // Configuration and status; an accepted REQ outranks a coincident valid_i.
  always_ff @(posedge clk_100m_i) begin
    if (!rstn_i) begin
      res_r     <= VGA_RES_800_600;
      scratch_r <= SCRATCH_RST;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      req_r     <= 1'b0;
    end else begin
      req_r <= 1'b0;
      if (do_write_s) begin
        res_r     <= res_nxt_s;
        scratch_r <= scratch_nxt_s;
      end
      if (do_write_s && req_fire_s) begin
        req_r  <= 1'b1;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end else if (valid_i) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_cfg_axil_regs.sv
// Directed bench for vga_cfg_axil_regs with queued expected write/read responses.
module tb_vga_cfg_axil_regs;
  import vga_cfg_axil_regs_pkg::*;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [10:0]     awaddr = 11'd0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [31:0]     wdata = 32'd0;
  logic [3:0]      wstrb = 4'd0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [10:0]     araddr = 11'd0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b0;
  vga_resolution_e resolution;
  logic            req;
  logic            vld = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {logic [1:0] resp; logic req;} wexp_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  vga_cfg_axil_regs dut (
    .clk_100m_i(clk), .rstn_i(rstn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .resolution_o(resolution), .req_o(req), .valid_i(vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for bvalid, compare against the oldest queued expectation, optionally stall bready.
  task automatic collect_b(input int stall);
    int n;
    wexp_t e;
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    check("b_latency", 64'(n), 64'd1);
    check("bvalid_seen", bvalid, 1'b1);
    e = wq.pop_front();
    check("bresp", bresp, e.resp);
    check("req_pulse", req, e.req);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("bvalid_stall", bvalid, 1'b1);
      check("bresp_stall", bresp, e.resp);
      check("awready_stall", awready, 1'b0);
      check("wready_stall", wready, 1'b0);
      check("req_stall", req, 1'b0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_clear", bvalid, 1'b0);
    check("req_single", req, 1'b0);
  endtask

  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input logic exp_req, input int stall);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    wq.push_back('{resp: exp_resp, req: exp_req});
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk);
      #0;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      #1;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
    collect_b(stall);
  endtask

  task automatic axi_read(input logic [10:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int stall);
    bit ar_hs;
    int n;
    rexp_t e;
    rq.push_back('{data: exp_data, resp: exp_resp});
    araddr = addr; arvalid = 1'b1;
    ar_hs = 1'b0; n = 0;
    while (!ar_hs && n < 20) begin
      ar_hs = arvalid && arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    check("rd_accept", ar_hs, 1'b1);
    check("rvalid_latency", rvalid, 1'b1);
    e = rq.pop_front();
    check("rdata", rdata, e.data);
    check("rresp", rresp, e.resp);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("rvalid_stall", rvalid, 1'b1);
      check("rdata_stall", rdata, e.data);
      check("arready_stall", arready, 1'b0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_clear", rvalid, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b1);
    check("rst_arready", arready, 1'b1);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_req", req, 1'b0);
    check("rst_res", resolution, VGA_RES_800_600);

    axi_read(11'h00C, 32'h5647_4131, 2'b00, 0);
    axi_read(11'h004, 32'h0000_0000, 2'b00, 0);
    axi_read(11'h008, 32'h0000_0000, 2'b00, 0);

    // W at cycle 0, AW at cycle 3, response one cycle after AW.
    wq.push_back('{resp: 2'b00, req: 1'b0});
    awaddr = 11'h008; wdata = 32'hDEAD_BEEF; wstrb = 4'b0101;
    wvalid = 1'b1;
    check("w_first_ready", wready, 1'b1);
    tick();
    wvalid = 1'b0;
    check("w_held_ready", wready, 1'b0);
    check("w_only_awready", awready, 1'b1);
    repeat (2) tick();
    check("w_only_bvalid", bvalid, 1'b0);
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("aw_edge_bvalid", bvalid, 1'b0);
    collect_b(0);
    axi_read(11'h008, 32'h00AD_00EF, 2'b00, 0);

    axi_write(11'h000, 32'h0000_0101, 4'b0011, 2'b00, 1'b1, 0);
    check("res_1280", resolution, VGA_RES_1280_1024);
    axi_read(11'h004, 32'h0000_0001, 2'b00, 0);
    axi_read(11'h000, 32'h0000_0100, 2'b00, 0);
    axi_write(11'h000, 32'h0000_0001, 4'b0001, 2'b10, 1'b0, 0);

    vld = 1'b1;
    tick();
    vld = 1'b0;
    axi_read(11'h004, 32'h0000_0002, 2'b00, 0);

    axi_write(11'h000, 32'h0000_0300, 4'b0010, 2'b10, 1'b0, 0);
    check("res_unchanged", resolution, VGA_RES_1280_1024);
    axi_write(11'h004, 32'h0000_0003, 4'b1111, 2'b10, 1'b0, 0);
    axi_read(11'h004, 32'h0000_0002, 2'b00, 0);
    axi_write(11'h00C, 32'h1111_1111, 4'b1111, 2'b10, 1'b0, 0);
    axi_read(11'h00C, 32'h5647_4131, 2'b00, 0);
    axi_read(11'h3FC, 32'h0000_0000, 2'b10, 0);

    axi_write(11'h00B, 32'h1234_5678, 4'b1111, 2'b00, 1'b0, 5);
    axi_read(11'h008, 32'h1234_5678, 2'b00, 3);

    // Reset while AW is held and W is being presented.
    awaddr = 11'h000; wdata = 32'h0000_0201; wstrb = 4'b0011;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mid_aw_held", awready, 1'b0);
    wvalid = 1'b1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wvalid = 1'b0;
    check("mid_bvalid", bvalid, 1'b0);
    check("mid_rvalid", rvalid, 1'b0);
    check("mid_req", req, 1'b0);
    check("mid_awready", awready, 1'b1);
    check("mid_wready", wready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_bvalid", bvalid, 1'b0);
      check("post_rst_req", req, 1'b0);
    end
    check("post_rst_res", resolution, VGA_RES_800_600);
    axi_read(11'h004, 32'h0000_0000, 2'b00, 0);
    axi_read(11'h000, 32'h0000_0000, 2'b00, 0);
    axi_read(11'h008, 32'h0000_0000, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
